// File: rtl/feature_pingpong_buf_pkg.sv
// Shared definitions for the ping-pong feature buffer.
//   - default feature/depth/tag widths used by the detection stage
//   - committed-bank count encoding for the pointer FSM
//   - address-width helper
package feature_pingpong_buf_pkg;

  localparam int FEAT_W_DEF = 32;
  localparam int DEPTH_DEF  = 128;
  localparam int TAG_W_DEF  = 13;

  // Number of banks holding a committed, unread window.
  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } cnt_e;

  // Address width for a given depth, never below one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/feature_pingpong_buf_fbram_dp.sv
// Simple dual-port RAM: one write port, one registered read port.
//   clk, rst_n : clock, async active-low reset (read register only)
//   we         : write enable
//   waddr/wdata: write address / data
//   raddr      : read address, sampled every cycle
//   rdata      : read data, one cycle latency
// The array itself is never reset.
module feature_pingpong_buf_fbram_dp #(
  parameter int W     = 32,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/feature_pingpong_buf.sv
// Two-bank feature buffer between the Haar feature generator and the ANN.
// The producer fills the write bank and commits it with a window tag; the
// consumer reads the oldest committed bank and releases it when done.
//   iClk, iReset_n : clock, async active-low reset
//   iWrreq/iWraddr/iFeature : feature write into the current write bank
//   iWin_done/iWin_tag      : commit the write bank with its window tag
//   iRdaddr                 : feature index read from the current read bank
//   iRelease                : free the current read bank
//   oFeature                : read data, latency 1
//   oValid / oFull_FBR      : >=1 bank committed / both banks committed
//   oWin_tag                : tag of the current read bank
//   oOverflow / oUnderflow  : sticky error flags
module feature_pingpong_buf
  import feature_pingpong_buf_pkg::*;
#(
  parameter  int FEAT_W = FEAT_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int TAG_W  = TAG_W_DEF,
  localparam int AW     = addr_w(DEPTH)
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iWrreq,
  input  logic [AW-1:0]     iWraddr,
  input  logic [FEAT_W-1:0] iFeature,
  input  logic              iWin_done,
  input  logic [TAG_W-1:0]  iWin_tag,
  input  logic [AW-1:0]     iRdaddr,
  input  logic              iRelease,
  output logic [FEAT_W-1:0] oFeature,
  output logic              oValid,
  output logic [TAG_W-1:0]  oWin_tag,
  output logic              oFull_FBR,
  output logic              oOverflow,
  output logic              oUnderflow
);

  cnt_e             cnt_q, cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [TAG_W-1:0] tag_q [2];
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic in_range;
  logic full, empty;
  logic wr_ok, commit_ok, rel_ok;

  // A power-of-two depth makes every address legal; only a ragged depth
  // needs the compare.
  if (DEPTH == (1 << AW)) begin : g_pow2
    assign in_range = 1'b1;
  end else begin : g_ragged
    assign in_range = (int'(iWraddr) < DEPTH);
  end

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == CNT_EMPTY);

  // All qualifiers use the pre-edge count, so a commit at full is dropped
  // even when a release lands in the same cycle.
  assign wr_ok     = iWrreq    && !full && in_range;
  assign commit_ok = iWin_done && !full;
  assign rel_ok    = iRelease  && !empty;

  // State register
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      cnt_q     <= CNT_EMPTY;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      if (commit_ok) tag_q[wr_bank_q] <= iWin_tag;
    end
  end

  // Next state: commit and release together move both pointers and
  // leave the count alone.
  always_comb begin
    cnt_d     = cnt_q;
    wr_bank_d = wr_bank_q ^ commit_ok;
    rd_bank_d = rd_bank_q ^ rel_ok;
    unique case (cnt_q)
      CNT_EMPTY: if (commit_ok) cnt_d = CNT_ONE;
      CNT_ONE: begin
        if (commit_ok && !rel_ok)      cnt_d = CNT_FULL;
        else if (rel_ok && !commit_ok) cnt_d = CNT_EMPTY;
      end
      CNT_FULL:  if (rel_ok) cnt_d = CNT_ONE;
      default:   cnt_d = CNT_EMPTY;
    endcase
    ovf_d = ovf_q | (iWrreq && (full || !in_range)) | (iWin_done && full);
    unf_d = unf_q | (iRelease && empty);
  end

  // Outputs
  always_comb begin
    oValid     = !empty;
    oFull_FBR  = full;
    oWin_tag   = tag_q[rd_bank_q];
    oOverflow  = ovf_q;
    oUnderflow = unf_q;
  end

  // Bank select is the address MSB. The write uses the pre-edge write
  // bank, so a write coincident with a commit lands in the committed bank.
  feature_pingpong_buf_fbram_dp #(
    .W     (FEAT_W),
    .DEPTH (2 * DEPTH),
    .AW    (AW + 1)
  ) u_ram (
    .clk   (iClk),
    .rst_n (iReset_n),
    .we    (wr_ok),
    .waddr ({wr_bank_q, iWraddr}),
    .wdata (iFeature),
    .raddr ({rd_bank_q, iRdaddr}),
    .rdata (oFeature)
  );

endmodule
